// File: rtl/axil_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axil_reg_slave
//  Description : AXI4-Lite slave exposing a bank of REG_COUNT read/write
//                registers of DATA_WIDTH bits each. The write address and
//                write data channels are captured independently into one-deep
//                holding registers. A write commits once both are held and
//                the B channel is free. Reads have one cycle of latency and
//                support back-to-back transfers. The read and write paths are
//                fully independent of each other.
//
//  Ports
//    clk                      : sole clock, rising edge
//    rst                      : asynchronous active-high reset
//    s_axil_aw*               : write address channel (awprot ignored)
//    s_axil_w*                : write data channel with byte strobes
//    s_axil_b*                : write response channel (OKAY / SLVERR)
//    s_axil_ar*               : read address channel (arprot ignored)
//    s_axil_r*                : read data channel (OKAY / SLVERR)
//
//  Revision    : 1.0  initial release
// ============================================================================
module axil_reg_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int REG_COUNT  = 16
) (
   input  logic                  clk,
   input  logic                  rst,

   // write address channel
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic [2:0]            s_axil_awprot,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,

   // write data channel
   input  logic [DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,

   // write response channel
   output logic [1:0]            s_axil_bresp,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,

   // read address channel
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [2:0]            s_axil_arprot,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,

   // read data channel
   output logic [DATA_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int                    c_ADDR_LSB    = $clog2(STRB_WIDTH);
   localparam int                    c_IDX_WIDTH   = $clog2(REG_COUNT);
   localparam logic [ADDR_WIDTH-1:0] c_REG_LIMIT   = ADDR_WIDTH'(REG_COUNT);
   localparam logic [1:0]            c_RESP_OKAY   = 2'b00;
   localparam logic [1:0]            c_RESP_SLVERR = 2'b10;

   // ------------------------------------------------------------------------
   // Register bank
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];

   // ------------------------------------------------------------------------
   // Write path state
   // ------------------------------------------------------------------------
   logic                  r_aw_held;
   logic [ADDR_WIDTH-1:0] r_awaddr;
   logic                  r_w_held;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_WIDTH-1:0] r_wstrb;
   logic                  r_bvalid;
   logic [1:0]            r_bresp;

   // ------------------------------------------------------------------------
   // Read path state
   // ------------------------------------------------------------------------
   logic                  r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp;

   // ------------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------------
   logic                   w_aw_fire;
   logic                   w_w_fire;
   logic                   w_commit;
   logic                   w_ar_fire;
   logic                   w_arready;

   logic [ADDR_WIDTH-1:0]  w_aw_word;
   logic                   w_aw_in_range;
   logic [c_IDX_WIDTH-1:0] w_aw_idx;

   logic [ADDR_WIDTH-1:0]  w_ar_word;
   logic                   w_ar_in_range;
   logic [c_IDX_WIDTH-1:0] w_ar_idx;

   logic [DATA_WIDTH-1:0]  w_wmask;

   // Protection attributes carry no meaning for this register file.
   logic                   w_unused_prot;
   assign w_unused_prot = ^{s_axil_awprot, s_axil_arprot};

   // Holding registers are one deep, so ready is simply "slot empty". Both
   // come straight from flops, keeping valid->ready free of any comb path.
   assign w_aw_fire = s_axil_awvalid && !r_aw_held;
   assign w_w_fire  = s_axil_wvalid  && !r_w_held;

   // A write may commit whenever the response slot is empty or is being
   // drained on this very edge.
   assign w_commit  = r_aw_held && r_w_held && (!r_bvalid || s_axil_bready);

   assign w_arready = !r_rvalid || s_axil_rready;
   assign w_ar_fire = s_axil_arvalid && w_arready;

   // Word decode. The in-range test uses the full shifted address so that
   // any set bit above the register index yields SLVERR instead of aliasing.
   assign w_aw_word     = r_awaddr >> c_ADDR_LSB;
   assign w_aw_in_range = (w_aw_word < c_REG_LIMIT);
   assign w_aw_idx      = w_aw_word[c_IDX_WIDTH-1:0];

   assign w_ar_word     = s_axil_araddr >> c_ADDR_LSB;
   assign w_ar_in_range = (w_ar_word < c_REG_LIMIT);
   assign w_ar_idx      = w_ar_word[c_IDX_WIDTH-1:0];

   // Expand byte strobes into a bit mask for the merge below.
   generate
      for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
         assign w_wmask[gi*8 +: 8] = {8{r_wstrb[gi]}};
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Write address / data holding registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_aw_held <= 1'b0;
         r_awaddr  <= '0;
      end else if (w_commit) begin
         r_aw_held <= 1'b0;
      end else if (w_aw_fire) begin
         r_aw_held <= 1'b1;
         r_awaddr  <= s_axil_awaddr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_w_held <= 1'b0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
      end else if (w_commit) begin
         r_w_held <= 1'b0;
      end else if (w_w_fire) begin
         r_w_held <= 1'b1;
         r_wdata  <= s_axil_wdata;
         r_wstrb  <= s_axil_wstrb;
      end
   end

   // ------------------------------------------------------------------------
   // Write response
   // ------------------------------------------------------------------------
   // A commit on the same edge as a B handshake keeps bvalid high and loads
   // the new response, giving back-to-back write responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bvalid <= 1'b0;
         r_bresp  <= c_RESP_OKAY;
      end else if (w_commit) begin
         r_bvalid <= 1'b1;
         r_bresp  <= w_aw_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
      end else if (s_axil_bready) begin
         r_bvalid <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Register bank update
   // ------------------------------------------------------------------------
   // Non-blocking update means a read sampled on the commit edge still sees
   // the old contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_commit && w_aw_in_range) begin
         r_regs[w_aw_idx] <= (r_regs[w_aw_idx] & ~w_wmask) | (r_wdata & w_wmask);
      end
   end

   // ------------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= c_RESP_OKAY;
      end else if (w_ar_fire) begin
         r_rvalid <= 1'b1;
         if (w_ar_in_range) begin
            r_rdata <= r_regs[w_ar_idx];
            r_rresp <= c_RESP_OKAY;
         end else begin
            r_rdata <= '0;
            r_rresp <= c_RESP_SLVERR;
         end
      end else if (s_axil_rready) begin
         r_rvalid <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign s_axil_awready = !r_aw_held;
   assign s_axil_wready  = !r_w_held;
   assign s_axil_bvalid  = r_bvalid;
   assign s_axil_bresp   = r_bresp;
   assign s_axil_arready = w_arready;
   assign s_axil_rvalid  = r_rvalid;
   assign s_axil_rdata   = r_rdata;
   assign s_axil_rresp   = r_rresp;

endmodule
`default_nettype wire
